// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S receive path: FSM states, channel encoding
// and the default sample width common with the transmitter.
package i2s_pkg;

  typedef enum logic [1:0] {
    S_SYNC  = 2'd0,
    S_LEFT  = 2'd1,
    S_RIGHT = 2'd2
  } state_t;

  localparam logic LRCLK_LEFT = 1'b0;

  localparam int DATA_W = 24;

endpackage

// File: rtl/i2s_sync_edge.sv
// Two-flop synchroniser for an asynchronous pin plus a registered rising-edge
// detect on the synchronised level.
module i2s_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise
);

  logic meta_p0;
  logic sync_p1;
  logic prev_p2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      prev_p2 <= 1'b0;
      rise    <= 1'b0;
    end else begin
      meta_p0 <= d;
      sync_p1 <= meta_p0;
      prev_p2 <= sync_p1;
      rise    <= sync_p1 & ~prev_p2;
    end
  end

  assign q = sync_p1;

endmodule

// File: rtl/i2s_rx.sv
// I2S receiver: oversamples SCLK/LRCLK/SD in the master-clock domain and
// delivers left/right sample pairs over a one-deep valid/ready interface.
module i2s_rx
  import i2s_pkg::*;
#(
  parameter int g_data_width = DATA_W,
  parameter int g_timeout    = 1024
) (
  input  logic                    i_mclk,
  input  logic                    i_mclk_rst_n,
  input  logic                    i_sclk,
  input  logic                    i_lrclk,
  input  logic                    i_sd,
  output logic [g_data_width-1:0] o_left_data,
  output logic [g_data_width-1:0] o_right_data,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic                    o_overrun,
  input  logic                    i_overrun_clr,
  output logic                    o_locked
);

  localparam int CNT_W = $clog2(g_data_width + 1);
  localparam int TO_W  = (g_timeout > 2) ? $clog2(g_timeout) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(g_data_width);
  localparam logic [TO_W-1:0]  TO_MAX  = TO_W'(g_timeout - 1);

  function automatic logic [TO_W-1:0] sat_inc(input logic [TO_W-1:0] v);
    return (v == TO_MAX) ? v : v + TO_W'(1);
  endfunction

  logic sclk_evt;
  logic lr_s;
  logic sd_s;
  logic unused_sclk_q;
  logic unused_lr_rise;
  logic unused_sd_rise;

  // Stage p0/p1: pin synchronisers, edge detect on the bit clock
  i2s_sync_edge u_sclk (
    .clk   (i_mclk),
    .rst_n (i_mclk_rst_n),
    .d     (i_sclk),
    .q     (unused_sclk_q),
    .rise  (sclk_evt)
  );

  i2s_sync_edge u_lrclk (
    .clk   (i_mclk),
    .rst_n (i_mclk_rst_n),
    .d     (i_lrclk),
    .q     (lr_s),
    .rise  (unused_lr_rise)
  );

  i2s_sync_edge u_sd (
    .clk   (i_mclk),
    .rst_n (i_mclk_rst_n),
    .d     (i_sd),
    .q     (sd_s),
    .rise  (unused_sd_rise)
  );

  // Stage p2: delay lrclk/sd by one cycle so they line up with the
  // registered edge pulse and reflect the pins at the sclk rising edge
  logic lr_p2;
  logic sd_p2;

  always_ff @(posedge i_mclk or negedge i_mclk_rst_n) begin
    if (!i_mclk_rst_n) begin
      lr_p2 <= 1'b0;
      sd_p2 <= 1'b0;
    end else begin
      lr_p2 <= lr_s;
      sd_p2 <= sd_s;
    end
  end

  logic                    lr_prev;
  logic                    lr_chg;
  logic [g_data_width-1:0] shreg;
  logic [g_data_width-1:0] shreg_sh;
  logic [g_data_width-1:0] word;
  logic [CNT_W-1:0]        bit_cnt;
  logic [CNT_W-1:0]        cnt_sh;
  logic [CNT_W-1:0]        shamt;
  logic [TO_W-1:0]         to_cnt;
  logic                    timeout;
  state_t                  state;
  state_t                  state_nx;
  logic                    left_ld;
  logic                    frame_done;
  logic [g_data_width-1:0] left_hold;

  assign lr_chg  = sclk_evt && (lr_p2 != lr_prev);
  assign timeout = !sclk_evt && (to_cnt == TO_MAX);

  // The word is finalised from the post-shift value so the bit sampled on
  // the lrclk change edge still lands as the outgoing channel's LSB.
  always_comb begin
    shreg_sh = shreg;
    cnt_sh   = bit_cnt;
    if (bit_cnt < CNT_MAX) begin
      shreg_sh = {shreg[g_data_width-2:0], sd_p2};
      cnt_sh   = bit_cnt + CNT_W'(1);
    end
    shamt = CNT_MAX - cnt_sh;
    word  = shreg_sh << shamt;
  end

  always_comb begin
    state_nx   = state;
    left_ld    = 1'b0;
    frame_done = 1'b0;
    if (timeout) begin
      state_nx = S_SYNC;
    end else if (lr_chg) begin
      case (state)
        S_SYNC: begin
          if (lr_p2 == LRCLK_LEFT) state_nx = S_LEFT;
        end
        S_LEFT: begin
          if (lr_p2 != LRCLK_LEFT) begin
            state_nx = S_RIGHT;
            left_ld  = 1'b1;
          end
        end
        S_RIGHT: begin
          if (lr_p2 == LRCLK_LEFT) begin
            state_nx   = S_LEFT;
            frame_done = 1'b1;
          end
        end
        default: state_nx = S_SYNC;
      endcase
    end
  end

  // Stage p3: deserialiser, frame FSM and link timeout
  always_ff @(posedge i_mclk or negedge i_mclk_rst_n) begin
    if (!i_mclk_rst_n) begin
      state   <= S_SYNC;
      lr_prev <= 1'b0;
      shreg   <= '0;
      bit_cnt <= '0;
      to_cnt  <= '0;
    end else begin
      state <= state_nx;
      if (sclk_evt) begin
        lr_prev <= lr_p2;
        to_cnt  <= '0;
      end else begin
        to_cnt <= sat_inc(to_cnt);
      end
      if (timeout || lr_chg) begin
        shreg   <= '0;
        bit_cnt <= '0;
      end else if (sclk_evt) begin
        shreg   <= shreg_sh;
        bit_cnt <= cnt_sh;
      end
    end
  end

  always_ff @(posedge i_mclk) begin
    if (left_ld) left_hold <= word;
  end

  // Stage p4: one-deep output register with overrun flag
  always_ff @(posedge i_mclk or negedge i_mclk_rst_n) begin
    if (!i_mclk_rst_n) begin
      o_left_data  <= '0;
      o_right_data <= '0;
      o_valid      <= 1'b0;
      o_overrun    <= 1'b0;
    end else begin
      if (frame_done && (!o_valid || i_ready)) begin
        o_left_data  <= left_hold;
        o_right_data <= word;
        o_valid      <= 1'b1;
      end else if (o_valid && i_ready) begin
        o_valid <= 1'b0;
      end
      if (frame_done && o_valid && !i_ready) begin
        o_overrun <= 1'b1;
      end else if (i_overrun_clr) begin
        o_overrun <= 1'b0;
      end
    end
  end

  assign o_locked = (state != S_SYNC);

endmodule

// File: tb/tb_i2s_rx.sv
// Directed bench for i2s_rx: a table of stereo frames streamed back to back,
// then hand sequences for backpressure, timeout and asynchronous reset.
module tb_i2s_rx;

  logic        mclk = 1'b0;
  logic        rst_n;
  logic        sclk;
  logic        lrclk;
  logic        sd;
  logic [23:0] left_data;
  logic [23:0] right_data;
  logic        valid;
  logic        ready;
  logic        overrun;
  logic        overrun_clr;
  logic        locked;

  i2s_rx #(.g_data_width(24), .g_timeout(1024)) dut (
    .i_mclk        (mclk),
    .i_mclk_rst_n  (rst_n),
    .i_sclk        (sclk),
    .i_lrclk       (lrclk),
    .i_sd          (sd),
    .o_left_data   (left_data),
    .o_right_data  (right_data),
    .o_valid       (valid),
    .i_ready       (ready),
    .o_overrun     (overrun),
    .i_overrun_clr (overrun_clr),
    .o_locked      (locked)
  );

  always #5 mclk = ~mclk;

  int n_vec  = 0;
  int n_miss = 0;
  int hs_cnt = 0;
  logic [23:0] ql[$];
  logic [23:0] qr[$];
  logic carry = 1'b0;
  logic skip  = 1'b0;

  // Records every accepted frame (values seen just before the clock edge).
  always @(posedge mclk) begin
    if (valid && ready) begin
      ql.push_back(left_data);
      qr.push_back(right_data);
      hs_cnt++;
    end
  end

  typedef struct {
    int          slot;
    logic [31:0] lval;
    logic [31:0] rval;
    logic [23:0] el;
    logic [23:0] er;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_frame(input string name, input logic [23:0] el, input logic [23:0] er);
    if (ql.size() == 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL %s: no frame received, expected 0x%0h/0x%0h", name, el, er);
    end else begin
      chk({name, "_left"}, 32'(ql.pop_front()), 32'(el));
      chk({name, "_right"}, 32'(qr.pop_front()), 32'(er));
    end
  endtask

  // One bit period (8 mclk): pins change with sclk low, sampled on sclk rise.
  task automatic send_period(input logic lr, input logic bit_v);
    sclk  = 1'b0;
    lrclk = lr;
    sd    = bit_v;
    repeat (4) @(negedge mclk);
    sclk = 1'b1;
    repeat (4) @(negedge mclk);
  endtask

  // Slot of n periods; data trails lrclk by one period (I2S delay).
  task automatic send_slot(input logic lr, input logic [31:0] val, input int n);
    for (int i = 0; i < n; i++) begin
      if (!(i == 0 && skip)) send_period(lr, carry);
      carry = val[31-i];
    end
    skip = 1'b0;
  endtask

  task automatic send_frame(input int n, input logic [31:0] l, input logic [31:0] r);
    send_slot(1'b0, l, n);
    send_slot(1'b1, r, n);
  endtask

  // First period of the next left slot; it carries the right LSB.
  // mode 1: latency check, mode 2: raise ready in the completion cycle.
  task automatic end_frame(input int mode);
    sclk  = 1'b0;
    lrclk = 1'b0;
    sd    = carry;
    repeat (4) @(negedge mclk);
    sclk = 1'b1;
    repeat (3) @(negedge mclk);
    if (mode == 1) chk("latency_3cyc_valid", 32'(valid), 32'd0);
    if (mode == 2) ready = 1'b1;
    @(negedge mclk);
    if (mode == 1) chk("latency_4cyc_valid", 32'(valid), 32'd1);
    skip = 1'b1;
  endtask

  initial begin
    int hs0;
    tbl[0] = '{32, 32'hA5A5A5FF, 32'h5A5A5A0F, 24'hA5A5A5, 24'h5A5A5A};
    tbl[1] = '{16, 32'hABCD0000, 32'h12340000, 24'hABCD00, 24'h123400};
    tbl[2] = '{24, 32'h80000100, 32'h7FFFFE00, 24'h800001, 24'h7FFFFE};
    tbl[3] = '{32, 32'hFFFFFFFF, 32'h000000FF, 24'hFFFFFF, 24'h000000};
    tbl[4] = '{20, 32'hFFFFF000, 32'h12345000, 24'hFFFFF0, 24'h123450};
    tbl[5] = '{28, 32'hC3C3C3F0, 32'h3C3C3C50, 24'hC3C3C3, 24'h3C3C3C};

    rst_n       = 1'b0;
    sclk        = 1'b0;
    lrclk       = 1'b0;
    sd          = 1'b0;
    ready       = 1'b1;
    overrun_clr = 1'b0;
    repeat (3) @(negedge mclk);
    chk("rst_left", 32'(left_data), 32'd0);
    chk("rst_right", 32'(right_data), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge mclk);

    // Partial right slot first: must be discarded, no lock yet
    send_slot(1'b1, 32'hDEADBEEF, 5);
    chk("locked_before_fall", 32'(locked), 32'd0);

    for (int k = 0; k < 6; k++) begin
      send_frame(tbl[k].slot, tbl[k].lval, tbl[k].rval);
      chk($sformatf("locked_%0d", k), 32'(locked), 32'd1);
      if (k > 0) chk_frame($sformatf("frame_%0d", k - 1), tbl[k-1].el, tbl[k-1].er);
    end
    end_frame(1);
    @(negedge mclk);
    chk_frame("frame_5", tbl[5].el, tbl[5].er);
    chk("no_extra_frames", 32'(ql.size()), 32'd0);

    // Backpressure: second frame dropped, first held
    ready = 1'b0;
    send_frame(32, 32'h11111100, 32'h22222200);
    send_frame(32, 32'h33333300, 32'h44444400);
    end_frame(0);
    chk("bp_valid", 32'(valid), 32'd1);
    chk("bp_left", 32'(left_data), 32'h111111);
    chk("bp_right", 32'(right_data), 32'h222222);
    chk("bp_overrun", 32'(overrun), 32'd1);
    ready = 1'b1;
    @(negedge mclk);
    ready = 1'b0;
    chk("bp_valid_drop", 32'(valid), 32'd0);
    chk("bp_left_hold", 32'(left_data), 32'h111111);
    chk("bp_overrun_sticky", 32'(overrun), 32'd1);
    overrun_clr = 1'b1;
    @(negedge mclk);
    overrun_clr = 1'b0;
    chk("overrun_clr", 32'(overrun), 32'd0);

    // New frame completes in the same cycle the held one is accepted
    send_frame(24, 32'h0F0F0F00, 32'hF0F0F000);
    send_frame(24, 32'h80000100, 32'h0F0F0F00);
    end_frame(2);
    chk("co_valid", 32'(valid), 32'd1);
    chk("co_left", 32'(left_data), 32'h800001);
    chk("co_right", 32'(right_data), 32'h0F0F0F);
    chk("co_overrun", 32'(overrun), 32'd0);
    @(negedge mclk);
    chk("co_valid_drop", 32'(valid), 32'd0);

    // Bit clock stops mid left slot
    ql.delete();
    qr.delete();
    send_slot(1'b0, 32'hFFFF0000, 6);
    repeat (1000) @(negedge mclk);
    chk("to_locked_1000", 32'(locked), 32'd1);
    repeat (100) @(negedge mclk);
    chk("to_locked_1100", 32'(locked), 32'd0);
    chk("to_valid", 32'(valid), 32'd0);
    hs0 = hs_cnt;
    send_slot(1'b0, 32'h12345678, 10);
    send_slot(1'b1, 32'h9ABCDEF0, 32);
    end_frame(0);
    @(negedge mclk);
    chk("to_relock", 32'(locked), 32'd1);
    chk("to_no_frame", 32'(hs_cnt), 32'(hs0));
    send_frame(24, 32'h13579B00, 32'h2468AC00);
    end_frame(0);
    @(negedge mclk);
    chk("to_one_frame", 32'(hs_cnt), 32'(hs0 + 1));
    chk_frame("to_frame", 24'h13579B, 24'h2468AC);

    // Asynchronous reset mid right slot with valid and overrun set
    ready = 1'b0;
    send_frame(32, 32'hAAAAAA00, 32'hBBBBBB00);
    send_frame(32, 32'hCCCCCC00, 32'hDDDDDD00);
    send_slot(1'b0, 32'hEEEEEE00, 32);
    send_slot(1'b1, 32'h77777700, 10);
    chk("ar_pre_valid", 32'(valid), 32'd1);
    chk("ar_pre_overrun", 32'(overrun), 32'd1);
    chk("ar_pre_left", 32'(left_data), 32'hAAAAAA);
    #1 rst_n = 1'b0;
    #1;
    chk("ar_valid", 32'(valid), 32'd0);
    chk("ar_overrun", 32'(overrun), 32'd0);
    chk("ar_locked", 32'(locked), 32'd0);
    chk("ar_left", 32'(left_data), 32'd0);
    chk("ar_right", 32'(right_data), 32'd0);
    @(negedge mclk);
    rst_n = 1'b1;
    repeat (2) @(negedge mclk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
